// File: rtl/keypad_pkg.sv
// Shared types and geometry for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  localparam int KP_KEYS = 16;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    PUBLISH
  } scan_state_t;

  function automatic int key_idx(input int row, input int col);
    return row * KP_COLS + col;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous GPIO inputs; resets to released (all ones).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner: drives one column low at a time and publishes a raw
// 16-bit key snapshot once per frame.
// state   | meaning
// IDLE    | columns released, waiting for scan_en
// DRIVE   | pull current column low, clear settle counter
// SETTLE  | hold column for SETTLE_CYCLES while rows settle
// SAMPLE  | capture synced rows into accumulator, advance column
// PUBLISH | copy accumulator to keypad_scan, start next frame or park
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES = 500
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               scan_en,
  input  logic [KP_ROWS-1:0] row_n,
  output logic [KP_COLS-1:0] col_n,
  output logic [KP_KEYS-1:0] keypad_scan,
  output logic               frame_done,
  output logic               multi_key
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > 65535) begin : g_bad_settle
    $error("keypad_scanner: SETTLE_CYCLES must be within 3..65535");
  end

  scan_state_t        state_q, state_d;
  logic [1:0]         col_q, col_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KP_KEYS-1:0] acc_q, acc_d;
  logic [KP_KEYS-1:0] scan_q, scan_d;
  logic               multi_q, multi_d;
  logic               done_q, done_d;
  logic [KP_ROWS-1:0] row_sync_n;
  logic [KP_COLS-1:0] col_n_c;
  logic [3:0]         idx;

  sync_2ff #(.WIDTH(KP_ROWS)) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_n),
    .q     (row_sync_n)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    scan_d  = scan_q;
    multi_d = multi_q;
    done_d  = 1'b0;
    col_n_c = 4'b1111;
    idx     = '0;
    case (state_q)
      IDLE: begin
        if (scan_en) begin
          state_d = DRIVE;
          col_d   = '0;
        end
      end
      DRIVE: begin
        col_n_c = ~(4'b0001 << col_q);
        cnt_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        col_n_c = ~(4'b0001 << col_q);
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        col_n_c = ~(4'b0001 << col_q);
        for (int r = 0; r < KP_ROWS; r++) begin
          idx        = 4'(key_idx(r, int'(col_q)));
          acc_d[idx] = ~row_sync_n[r];
        end
        if (col_q == 2'd3) begin
          state_d = PUBLISH;
        end else begin
          col_d   = col_q + 1'b1;
          state_d = DRIVE;
        end
      end
      PUBLISH: begin
        scan_d  = acc_q;
        // More than one bit set iff clearing the lowest set bit leaves something.
        multi_d = |(acc_q & (acc_q - 1'b1));
        done_d  = 1'b1;
        acc_d   = '0;
        col_d   = '0;
        state_d = scan_en ? DRIVE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      scan_q  <= '0;
      multi_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      scan_q  <= scan_d;
      multi_q <= multi_d;
      done_q  <= done_d;
    end
  end

  // Decoded from state so reset releases the columns without a clock edge.
  assign col_n       = col_n_c;
  assign keypad_scan = scan_q;
  assign frame_done  = done_q;
  assign multi_key   = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix (SETTLE_CYCLES = 4).
module tb_keypad_scanner;

  logic        clk;
  logic        rst_n;
  logic        scan_en;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] keypad_scan;
  logic        frame_done;
  logic        multi_key;

  logic [15:0] keys;
  logic        glitch_row1;
  int          checks;
  int          errors;

  keypad_scanner #(.SETTLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_en     (scan_en),
    .row_n       (row_n),
    .col_n       (col_n),
    .keypad_scan (keypad_scan),
    .frame_done  (frame_done),
    .multi_key   (multi_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pressed key shorts its row to its column; a driven-low column pulls the row low.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    if (glitch_row1) row_n[1] = 1'b0;
  end

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 100);
    if (!frame_done) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: no frame_done within %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    int n;
    rst_n = 1'b0; scan_en = 1'b1; keys = '0; glitch_row1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (col_n !== 4'b1111) begin errors++; $display("FAIL reset_col_n: got %b want 1111", col_n); end
    checks++; if (keypad_scan !== 16'h0000) begin errors++; $display("FAIL reset_scan: got %h want 0000", keypad_scan); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
    checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL reset_multi: got %b want 0", multi_key); end
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      exp_col = (i < 24) ? ~(4'b0001 << (i / 6)) : 4'b1111;
      checks++;
      if (col_n !== exp_col || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL seq_cycle%0d: col_n %b done %b want col_n %b done 0", i, col_n, frame_done, exp_col);
      end
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1 || col_n !== 4'b1110 || keypad_scan !== 16'h0000) begin
      errors++;
      $display("FAIL first_frame: done %b col_n %b scan %h want 1 1110 0000", frame_done, col_n, keypad_scan);
    end
    wait_frame(n);
    checks++; if (n !== 25) begin errors++; $display("FAIL frame_period: got %0d want 25", n); end
  endtask

  task automatic test_single_key();
    int n;
    keys = 16'h0200;
    wait_frame(n);
    checks++; if (keypad_scan !== 16'h0200) begin errors++; $display("FAIL single_scan: got %h want 0200", keypad_scan); end
    checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL single_multi: got %b want 0", multi_key); end
    @(negedge clk);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b want 0", frame_done); end
    checks++; if (keypad_scan !== 16'h0200) begin errors++; $display("FAIL single_hold: got %h want 0200", keypad_scan); end
    keys = 16'h0000;
    wait_frame(n);
    wait_frame(n);
    checks++; if (keypad_scan !== 16'h0000) begin errors++; $display("FAIL release_scan: got %h want 0000", keypad_scan); end
  endtask

  task automatic test_two_keys();
    int n;
    keys = 16'h8001;
    wait_frame(n);
    checks++; if (keypad_scan !== 16'h8001) begin errors++; $display("FAIL two_scan: got %h want 8001", keypad_scan); end
    checks++; if (multi_key !== 1'b1) begin errors++; $display("FAIL two_multi: got %b want 1", multi_key); end
    keys = 16'h0000;
    wait_frame(n);
    checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL multi_clear: got %b want 0", multi_key); end
  endtask

  task automatic test_glitch();
    int n;
    keys = 16'h0000;
    repeat (13) @(negedge clk);
    glitch_row1 = 1'b1;
    @(negedge clk);
    glitch_row1 = 1'b0;
    wait_frame(n);
    checks++; if (keypad_scan !== 16'h0000) begin errors++; $display("FAIL glitch_ignored: got %h want 0000", keypad_scan); end
    repeat (13) @(negedge clk);
    glitch_row1 = 1'b1;
    repeat (5) @(negedge clk);
    glitch_row1 = 1'b0;
    wait_frame(n);
    checks++; if (keypad_scan !== 16'h0040) begin errors++; $display("FAIL held_row_sampled: got %h want 0040", keypad_scan); end
  endtask

  task automatic test_disable();
    int n;
    int bad;
    keys = 16'h0020;
    repeat (8) @(negedge clk);
    scan_en = 1'b0;
    wait_frame(n);
    checks++; if (n !== 17) begin errors++; $display("FAIL disable_completes: got %0d want 17", n); end
    checks++; if (keypad_scan !== 16'h0020) begin errors++; $display("FAIL disable_scan: got %h want 0020", keypad_scan); end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (col_n !== 4'b1111 || frame_done !== 1'b0 || keypad_scan !== 16'h0020) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL parked_idle: %0d bad cycles want 0", bad); end
    keys = 16'h0400;
    scan_en = 1'b1;
    @(negedge clk);
    checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL restart_col0: got %b want 1110", col_n); end
    wait_frame(n);
    checks++; if (n !== 25) begin errors++; $display("FAIL restart_period: got %0d want 25", n); end
    checks++; if (keypad_scan !== 16'h0400) begin errors++; $display("FAIL restart_scan: got %h want 0400", keypad_scan); end
  endtask

  task automatic test_async_reset();
    int n;
    keys = 16'h1008;
    repeat (20) @(negedge clk);
    checks++; if (col_n !== 4'b0111) begin errors++; $display("FAIL pre_reset_col3: got %b want 0111", col_n); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (col_n !== 4'b1111) begin errors++; $display("FAIL async_col_release: got %b want 1111", col_n); end
    checks++; if (keypad_scan !== 16'h0000) begin errors++; $display("FAIL async_scan_clear: got %h want 0000", keypad_scan); end
    @(negedge clk);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL async_no_publish: got %b want 0", frame_done); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL post_reset_col0: got %b want 1110", col_n); end
    wait_frame(n);
    checks++; if (n !== 25) begin errors++; $display("FAIL post_reset_period: got %0d want 25", n); end
    checks++; if (keypad_scan !== 16'h1008) begin errors++; $display("FAIL post_reset_scan: got %h want 1008", keypad_scan); end
    checks++; if (multi_key !== 1'b1) begin errors++; $display("FAIL post_reset_multi: got %b want 1", multi_key); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_key();
    test_two_keys();
    test_glitch();
    test_disable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives a 4x4 membrane keypad on the DE10-Lite GPIO header: one column low at a time, rows read back through synchronizers.
- Assembles one 16-bit snapshot per full scan frame and presents it to the downstream debouncer as its raw key vector. The debouncer's 16-bit input is this block's keypad_scan.
- Reports raw key state only; it does no debouncing.

Parameters:
- SETTLE_CYCLES, 500, clk cycles a driven column is held before rows are sampled (10 us at 50 MHz). Legal range 3..65535; elaboration error outside it.

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- scan_en  in  1  1 = scanning enabled; 0 = park at idle
- row_n  in  4  keypad row inputs, active-low (external pull-ups), asynchronous to clk
- col_n  out  4  keypad column drives, active-low, at most one bit low
- keypad_scan  out  16  latest completed snapshot; bit = row*4 + col, 1 = pressed
- frame_done  out  1  one-cycle pulse when keypad_scan is updated
- multi_key  out  1  1 when the published snapshot has more than one bit set

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n; every flop clears on it.
- Reset values:
  - col_n = 4'b1111; keypad_scan = 0; frame_done = 0; multi_key = 0.
  - FSM = IDLE; column index = 0; accumulator = 0; settle counter = 0; synchronizer flops = 4'b1111 (released).
- Row synchronizer: two flops per row bit, reset high. Sampled row value = ~row_n delayed 2 clk.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, PUBLISH.
- IDLE:
  - col_n = 1111.
  - If scan_en = 1, go to DRIVE with column = 0; otherwise stay.
- DRIVE (1 cycle):
  - col_n = ~(1 << column); counter cleared.
  - Go to SETTLE.
- SETTLE (exactly SETTLE_CYCLES cycles):
  - col_n unchanged; counter increments.
  - Leave when counter == SETTLE_CYCLES-1.
- SAMPLE (1 cycle):
  - col_n unchanged.
  - For each row r, accumulator bit r*4+column <= synced row r.
  - If column == 3, go to PUBLISH; else column + 1 and go to DRIVE.
- PUBLISH (1 cycle):
  - col_n = 1111.
  - keypad_scan <= accumulator, including the column-3 bits written in the preceding SAMPLE.
  - multi_key <= (popcount(accumulator) > 1); frame_done = 1 this cycle only.
  - Accumulator cleared; column = 0.
  - Next state is DRIVE if scan_en = 1, else IDLE.
- Frame length: 4*(SETTLE_CYCLES+2)+1 cycles; 25 for SETTLE_CYCLES = 4.
- Output update: keypad_scan and multi_key change only in the cycle after PUBLISH, i.e. registered, and hold between frames. frame_done is high for the same cycle as the new keypad_scan.
- scan_en rules:
  - scan_en is examined only in IDLE and PUBLISH. A frame in progress always completes.
  - While disabled, keypad_scan holds its last value and col_n = 1111.
- No ghost suppression: all pressed bits are reported and multi_key flags the condition.
- Downstream treats any change of the vector as a new key. Snapshots change only at frame boundaries, which guarantees vector stability for at least one frame.
- Reset mid-frame: asynchronous return to the reset values; col_n is released immediately and no partial snapshot is ever published.
- Row activity during DRIVE or SETTLE is ignored. Only the SAMPLE-cycle synced value counts.
- Counter width: $clog2(SETTLE_CYCLES+1) bits; it never wraps within legal SETTLE_CYCLES.

Decomposition:
- Package keypad_pkg:
  - scan_state_t enum (IDLE, DRIVE, SETTLE, SAMPLE, PUBLISH).
  - KP_ROWS = 4, KP_COLS = 4, KP_KEYS = 16.
  - Key index function key_idx(row, col) = row*KP_COLS + col.
- Sub-module sync_2ff:
  - Parameterized width, reset value 1.
  - Used for row_n and reusable by the other GPIO input stages.

Test Plan:
- Reset check, SETTLE_CYCLES = 4: hold rst_n low with scan_en = 1 -> col_n = 1111, keypad_scan = 0, frame_done = 0. Release -> col_n sequence 1110, 1101, 1011, 0111 (6 cycles each), then 1111 for 1 cycle with frame_done pulse; period 25 cycles.
- Single key: key row2/col1 pressed, i.e. row_n[2] pulled low while col_n[1] = 0 -> after the frame, keypad_scan = 16'h0200, multi_key = 0. On release, the next frame gives keypad_scan = 16'h0000.
- Two keys: row0/col0 and row3/col3 -> keypad_scan = 16'h8001, multi_key = 1.
- Glitch immunity: row_n[1] low only during SETTLE of column 2, released 3 cycles before SAMPLE -> bit 6 = 0 in the snapshot.
- Disable mid-frame: scan_en -> 0 during column 1 -> frame completes, frame_done pulses once, then col_n = 1111 and keypad_scan holds. Re-enable -> scanning restarts at column 0.
- Async reset in SETTLE of column 3 with keys held -> col_n = 1111 without waiting for a clock edge, and keypad_scan = 0. After release, the first frame_done occurs 25 cycles after leaving IDLE.
